// File: rtl/mux_scan_sel_pkg.sv
// Shared definitions for the mux_scan_sel block.
//   - mode encodings (manual / scan)
//   - top-level state encoding
//   - clog2 helper used for counter sizing
package mux_scan_sel_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } st_e;

    // ceil(log2(v)); returns 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_sel_if.sv
// Bus interface for mux_scan_sel.
//   master: drives en_n, mode, sel, din (and ch_mask when MUX_SCAN_MASK_EN
//           is defined); observes dout, dout_vld, cur_ch, wrap.
//   slave : the selector itself.
// Optional macro: MUX_SCAN_MASK_EN adds the ch_mask signal.
interface mux_scan_sel_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 1,
    parameter int SEL_W  = 2
) ();
    logic                       en_n;
    logic                       mode;
    logic [SEL_W-1:0]           sel;
    logic [NUM_CH*DATA_W-1:0]   din;
`ifdef MUX_SCAN_MASK_EN
    logic [NUM_CH-1:0]          ch_mask;
`endif
    logic [DATA_W-1:0]          dout;
    logic                       dout_vld;
    logic [SEL_W-1:0]           cur_ch;
    logic                       wrap;

    modport master (
        output en_n, mode, sel, din,
`ifdef MUX_SCAN_MASK_EN
        output ch_mask,
`endif
        input  dout, dout_vld, cur_ch, wrap
    );

    modport slave (
        input  en_n, mode, sel, din,
`ifdef MUX_SCAN_MASK_EN
        input  ch_mask,
`endif
        output dout, dout_vld, cur_ch, wrap
    );
endinterface

// File: rtl/mux_scan_sel_scan_dwell_ctr.sv
// scan_dwell_ctr: dwell counter plus channel stepper for scan mode.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   active       scan state is selected for this edge
//   start        this edge enters scan (previous state was not scan)
//   mask         channels eligible for scanning (all ones when unmasked)
//   step         this edge advances to another channel
//   cur_ch       channel the scan occupies after this edge
//   wrap         this edge's advance wraps past the last eligible channel
//   none         no channel is eligible (mask all zero) during scan
// Outputs are the next-edge values; the top registers them alongside dout.
module scan_dwell_ctr
    import mux_scan_sel_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DWELL  = 4,
    parameter int SEL_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               active,
    input  logic               start,
    input  logic [NUM_CH-1:0]  mask,
    output logic               step,
    output logic [SEL_W-1:0]   cur_ch,
    output logic               wrap,
    output logic               none
);
    localparam int CNT_W = clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] ch;
    // set after an all-zero-mask edge so the scan restarts cleanly at the
    // lowest eligible channel once any mask bit returns
    logic             hold;

    logic [SEL_W-1:0] first, adv_ch, ki;
    logic             adv_wrap, found, wr;
    int               idx;

    // lowest eligible channel, and the next eligible one after ch (modulo)
    always_comb begin
        first = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (mask[i]) first = SEL_W'(i);

        adv_ch   = ch;
        adv_wrap = 1'b0;
        found    = 1'b0;
        idx      = 0;
        wr       = 1'b0;
        ki       = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(ch) + i;
            wr  = (idx >= NUM_CH);
            if (wr) idx = idx - NUM_CH;
            ki  = SEL_W'(idx);
            if (!found && mask[ki]) begin
                found    = 1'b1;
                adv_ch   = ki;
                adv_wrap = wr;
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        cur_ch  = '0;
        step    = 1'b0;
        wrap    = 1'b0;
        none    = 1'b0;
        if (active) begin
            if (mask == '0) begin
                none   = 1'b1;
                cur_ch = ch;
            end else if (start || hold) begin
                cur_ch = first;
            end else if (cnt == CNT_MAX) begin
                step   = 1'b1;
                cur_ch = adv_ch;
                wrap   = adv_wrap;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
                cur_ch  = ch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            ch   <= '0;
            hold <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            ch   <= cur_ch;
            hold <= none;
        end
    end
endmodule

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N-channel data selector with manual and scan modes.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous reset, active-low
//   bus    mux_scan_sel_if.slave: en_n, mode, sel, din, [ch_mask] in;
//          dout, dout_vld, cur_ch, wrap out (all registered)
// Optional macro: MUX_SCAN_MASK_EN enables ch_mask channel skipping in scan.
// State follows en_n/mode at every edge; outputs are written in the same
// always_ff so they carry exactly one clock of latency.
module mux_scan_sel
    import mux_scan_sel_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 1,
    parameter int DWELL  = 4,
    parameter int SEL_W  = 2
) (
    input logic           clk,
    input logic           rst_n,
    mux_scan_sel_if.slave bus
);
    localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(NUM_CH);

    st_e state, st_nxt;

    logic [NUM_CH-1:0][DATA_W-1:0] din_arr;
    logic [NUM_CH-1:0]             scan_mask;
    logic                          scan_step, scan_wrap, scan_none;
    logic [SEL_W-1:0]              scan_ch;

    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic [SEL_W-1:0]  cur_ch;
    logic              wrap;

    assign din_arr = bus.din;

`ifdef MUX_SCAN_MASK_EN
    assign scan_mask = bus.ch_mask;
`else
    assign scan_mask = '1;
`endif

    always_comb begin
        if (bus.en_n)                   st_nxt = ST_IDLE;
        else if (bus.mode == MODE_SCAN) st_nxt = ST_SCAN;
        else                            st_nxt = ST_MANUAL;
    end

    scan_dwell_ctr #(
        .NUM_CH (NUM_CH),
        .DWELL  (DWELL),
        .SEL_W  (SEL_W)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (st_nxt == ST_SCAN),
        .start  (state != ST_SCAN),
        .mask   (scan_mask),
        .step   (scan_step),
        .cur_ch (scan_ch),
        .wrap   (scan_wrap),
        .none   (scan_none)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dout     <= '0;
            dout_vld <= 1'b0;
            cur_ch   <= '0;
            wrap     <= 1'b0;
        end else begin
            state <= st_nxt;
            wrap  <= 1'b0;
            case (st_nxt)
                ST_MANUAL: begin
                    cur_ch <= bus.sel;
                    // non-power-of-2 NUM_CH leaves unused sel codes
                    if ({1'b0, bus.sel} < NCH) begin
                        dout     <= din_arr[bus.sel];
                        dout_vld <= 1'b1;
                    end else begin
                        dout     <= '0;
                        dout_vld <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (scan_none) begin
                        dout     <= '0;
                        dout_vld <= 1'b0;
                    end else begin
                        cur_ch   <= scan_ch;
                        dout     <= din_arr[scan_ch];
                        dout_vld <= 1'b1;
                        wrap     <= scan_step & scan_wrap;
                    end
                end
                default: begin
                    dout     <= '0;
                    dout_vld <= 1'b0;
                    cur_ch   <= '0;
                end
            endcase
        end
    end

    assign bus.dout     = dout;
    assign bus.dout_vld = dout_vld;
    assign bus.cur_ch   = cur_ch;
    assign bus.wrap     = wrap;
endmodule
